ece453_step_scheduler: RTL and testbench
========================================

# ece453_step_scheduler

Sequencing controller for the ECE453 LED-position datapath. It decides when the LED position advances, and in which direction, by arbitrating between debounced push-button requests and an internal programmable step timer. Each step is a single-cycle strobe plus a 2-bit position. It also produces an end-of-travel interrupt pulse that feeds the slave's IRQ register. It sits between the Avalon register block (control/period registers) and the LED/GPIO output path.

## Interface
- PERIOD_W, 24, width of the step-period register and down-counter
- DEFAULT_PERIOD, 500000, period register value after reset (clock cycles per auto step)

- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  scheduler enable (control register bit)
- auto_mode  input  1  0 = steps on button only; 1 = steps on timer and button
- dir_in  input  1  requested direction: 1 = up (toward 3), 0 = down (toward 0)
- button_pulse  input  1  single-cycle debounced button request
- period_in  input  PERIOD_W  new step period
- period_load  input  1  capture period_in into period register
- step_pulse  output  1  registered single-cycle strobe, one per accepted step
- position  output  2  current LED position, 0..3
- cur_dir  output  1  effective direction used for the last or next step
- state  output  2  FSM state code, for the status register
- end_irq  output  1  single-cycle pulse when position enters 0 or 3 via a step

## Operation
- States:
  - IDLE = 0
  - MANUAL = 1
  - AUTO = 2
  - STEP = 3
- IDLE:
  - position is held.
  - enable=1 goes to MANUAL if auto_mode=0, otherwise to AUTO. On entering AUTO, the counter loads period-1.
- MANUAL: button_pulse goes to STEP.
- AUTO:
  - The counter decrements every cycle.
  - When counter==0, or when button_pulse is high, the FSM goes to STEP.
  - A simultaneous timer expiry and button_pulse produces exactly one step.
- STEP:
  - Lasts one cycle. Position is updated and step_pulse is asserted, both registered, so visible in the cycle after STEP.
  - The FSM then returns to MANUAL or AUTO according to the current auto_mode. The counter reloads period-1 on that return.
- Leaving enabled operation:
  - enable=0 in any state goes to IDLE on the next edge.
  - If the FSM is in STEP, the step completes and is not cancelled.
- Mode change: auto_mode changes while in MANUAL/AUTO take effect on the next edge, with the counter reloaded.
- Position arithmetic: unsigned 2-bit, saturating.
  - An up-step at 3 or a down-step at 0 is still "accepted": step_pulse fires, but position is unchanged and end_irq is not raised.
- Period register:
  - period_load captures period_in. Values below 2 are clamped to 2.
  - A new period takes effect at the next counter reload, not mid-count.
- cur_dir:
  - Follows dir_in, except when modified by the bounce feature (see Configuration).
- end_irq fires only when position changes into 0 or 3.

## Timing
- Reset values:
  - state = IDLE, position = 0, step_pulse = 0, end_irq = 0, cur_dir = 1.
  - Period register = DEFAULT_PERIOD; counter = DEFAULT_PERIOD-1.
- Manual latency: button_pulse at cycle N gives STEP at N+1, and position/step_pulse visible at N+2.
- Auto step spacing: period+1 cycles between step_pulses, because STEP occupies one cycle.
- Button in AUTO: forces an immediate step and restarts the full period count.
- button_pulse while in STEP or IDLE is ignored; it is not queued.
- end_irq is coincident with the step_pulse that caused the end-of-travel.
- Reset asserted mid-operation: all outputs return to reset values immediately, since reset is asynchronous.

## Configuration
- ECE453_SEQ_BOUNCE_EN:
  - Defined: in AUTO, a step that reaches 3 while moving up, or 0 while moving down, toggles cur_dir. Subsequent timer steps travel back (ping-pong), ignoring dir_in until dir_in changes level or the FSM passes through IDLE.
  - Undefined: cur_dir always equals dir_in, and the position saturates at the ends.

## Test plan
- Reset, then enable=1, auto_mode=0, dir_in=1, four button_pulses spaced 5 cycles apart -> position steps 1,2,3,3; four step_pulses; a single end_irq on the 2->3 step.
- auto_mode=1, period_load with period_in=10, dir_in=1 -> step_pulses spaced exactly 11 cycles apart; position counts 1,2,3.
- auto_mode=1, period 10, button_pulse in the same cycle as timer expiry -> exactly one step_pulse; the next step comes 11 cycles later.
- period_in=0 loaded -> clamped to 2, giving steps every 3 cycles; enable dropped mid-count -> IDLE next edge, position frozen, no further pulses.
- With ECE453_SEQ_BOUNCE_EN, auto period 4, dir_in=1 -> position sequence 1,2,3,2,1,0,1; end_irq at the reaches of 3 and 0. Without the macro -> 1,2,3,3,3.
- Assert reset while in STEP with position=2 -> position=0, state=0, step_pulse=0 with no clock edge required.

Source files
------------

// File: rtl/ece453_step_scheduler.sv
// Purpose : step sequencer for the ECE453 LED-position datapath; arbitrates button requests and a programmable step timer, optional ping-pong via ECE453_SEQ_BOUNCE_EN.
// Latency : button_pulse in cycle N -> STEP in N+1 -> step_pulse/position/end_irq registered and visible in N+2; auto steps every period+1 cycles.
// Backpressure: none; requests arriving in IDLE or STEP are dropped, never queued.
module ece453_step_scheduler #(
   parameter int PERIOD_W       = 24,
   parameter int DEFAULT_PERIOD = 500000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                auto_mode,
   input  logic                dir_in,
   input  logic                button_pulse,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                period_load,
   output logic                step_pulse,
   output logic [1:0]          position,
   output logic                cur_dir,
   output logic [1:0]          state,
   output logic                end_irq
);

   // State codes are visible in the status register, so they are fixed.
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] MANUAL = 2'd1;
   localparam logic [1:0] AUTO   = 2'd2;
   localparam logic [1:0] STEP   = 2'd3;

   // Periods below 2 would leave no room for a down-count between steps.
   localparam logic [PERIOD_W-1:0] MIN_PERIOD   = PERIOD_W'(2);
   localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(DEFAULT_PERIOD);
   localparam logic [PERIOD_W-1:0] RESET_COUNT  = PERIOD_W'(DEFAULT_PERIOD - 1);

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] counter_q;
   logic                timer_done;
   logic                eff_dir;
   logic                cur_dir_d;
   logic [1:0]          pos_next;
   logic                in_step;
   logic                irq_d;

   assign state      = state_q;
   assign in_step    = (state_q == STEP);
   assign timer_done = (counter_q == '0);

`ifdef ECE453_SEQ_BOUNCE_EN
   // Ping-pong: once an auto step hits an end, the reversed direction
   // overrides dir_in until dir_in toggles or the scheduler goes idle.
   logic step_auto_q;
   logic dir_prev_q;
   logic bounce_act_q;
   logic bounce_dir_q;
   logic bounce_hold;
   logic bounce_hit;
   logic at_end;

   assign bounce_hold = bounce_act_q && (state_q != IDLE) && (dir_in == dir_prev_q);
   assign eff_dir     = bounce_hold ? bounce_dir_q : dir_in;
   assign at_end      = (pos_next == (eff_dir ? 2'd3 : 2'd0));
   assign bounce_hit  = in_step && step_auto_q && at_end;
   assign cur_dir_d   = bounce_hit ? ~eff_dir : eff_dir;

   // Track the origin of the step, the previous dir_in level and the bounce override.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_auto_q  <= 1'b0;
         dir_prev_q   <= 1'b1;
         bounce_act_q <= 1'b0;
         bounce_dir_q <= 1'b0;
      end else begin
         step_auto_q <= (state_q == AUTO);
         dir_prev_q  <= dir_in;
         if (bounce_hit) begin
            bounce_act_q <= 1'b1;
            bounce_dir_q <= ~eff_dir;
         end else if (!bounce_hold) begin
            bounce_act_q <= 1'b0;
         end
      end
   end
`else
   // Without ping-pong the requested direction is always the one used.
   assign eff_dir   = dir_in;
   assign cur_dir_d = dir_in;
`endif

   // Saturating 2-bit move in the effective direction.
   always_comb begin
      pos_next = position;
      if (eff_dir) begin
         if (position != 2'd3) pos_next = position + 2'd1;
      end else begin
         if (position != 2'd0) pos_next = position - 2'd1;
      end
   end

   // end_irq only when the position actually moves onto an end stop.
   always_comb begin
      irq_d = 1'b0;
      if (in_step && (pos_next != position) &&
          ((pos_next == 2'd0) || (pos_next == 2'd3)))
         irq_d = 1'b1;
   end

   // Next-state: disable wins, then button, then mode change, then timer expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = auto_mode ? AUTO : MANUAL;
         end
         MANUAL: begin
            if (!enable)           state_d = IDLE;
            else if (button_pulse) state_d = STEP;
            else if (auto_mode)    state_d = AUTO;
         end
         AUTO: begin
            if (!enable)           state_d = IDLE;
            else if (button_pulse) state_d = STEP;
            else if (!auto_mode)   state_d = MANUAL;
            else if (timer_done)   state_d = STEP;
         end
         STEP: begin
            // The step in progress always completes, even if disabled.
            if (!enable)        state_d = IDLE;
            else if (auto_mode) state_d = AUTO;
            else                state_d = MANUAL;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Period register; a new value is only picked up at the next counter reload.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_q <= RESET_PERIOD;
      end else if (period_load) begin
         period_q <= (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
      end
   end

   // Down-counter runs only while staying in AUTO; every other path reloads it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter_q <= RESET_COUNT;
      end else if ((state_q == AUTO) && (state_d == AUTO)) begin
         counter_q <= counter_q - PERIOD_W'(1);
      end else begin
         counter_q <= period_q - PERIOD_W'(1);
      end
   end

   // Step outputs are registered so they appear the cycle after STEP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         position   <= 2'd0;
         step_pulse <= 1'b0;
         end_irq    <= 1'b0;
      end else begin
         step_pulse <= in_step;
         end_irq    <= irq_d;
         if (in_step) position <= pos_next;
      end
   end

   // Effective direction register for the status path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_dir <= 1'b1;
      else       cur_dir <= cur_dir_d;
   end

endmodule

// File: tb/tb_ece453_step_scheduler.sv
// Purpose : self-checking bench for ece453_step_scheduler (directed plan steps plus random traffic).
// Latency : reference model predicts outputs one edge at a time from the behavioural rules.
// Backpressure: n/a.
module tb_ece453_step_scheduler;
   localparam int PW  = 24;
   localparam int DEF = 500000;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          auto_mode;
   logic          dir_in;
   logic          button_pulse;
   logic [PW-1:0] period_in;
   logic          period_load;
   logic          step_pulse;
   logic [1:0]    position;
   logic          cur_dir;
   logic [1:0]    state;
   logic          end_irq;

   ece453_step_scheduler #(.PERIOD_W(PW), .DEFAULT_PERIOD(DEF)) dut (
      .clk(clk), .reset(reset), .enable(enable), .auto_mode(auto_mode),
      .dir_in(dir_in), .button_pulse(button_pulse), .period_in(period_in),
      .period_load(period_load), .step_pulse(step_pulse), .position(position),
      .cur_dir(cur_dir), .state(state), .end_irq(end_irq)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc_n      = 0;

   // Reference model: enabled/mode/stepping flags, cycles left before the timer fires.
   bit m_on, m_auto, m_stepping, m_step_auto;
   bit m_bact, m_bdir, m_prev_di;
   int m_left, m_per, m_pos;
   bit e_pulse, e_irq, e_dir;

   int pulse_t[$];
   int pulse_pos[$];
   int irq_pos[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   function automatic int exp_state();
      if (!m_on)      return 0;
      if (m_stepping) return 3;
      if (m_auto)     return 2;
      return 1;
   endfunction

   task automatic model_reset();
      m_on = 0; m_auto = 0; m_stepping = 0; m_step_auto = 0;
      m_bact = 0; m_bdir = 0; m_prev_di = 1;
      m_left = 0; m_per = DEF; m_pos = 0;
      e_pulse = 0; e_irq = 0; e_dir = 1;
   endtask

   // One clock edge of the specified behaviour, using the inputs currently driven.
   task automatic model_edge();
      bit eff;
      bit hit;
      int np;
`ifdef ECE453_SEQ_BOUNCE_EN
      bit hold;
      hold = m_bact && m_on && (dir_in == m_prev_di);
      eff  = hold ? m_bdir : dir_in;
`else
      eff  = dir_in;
`endif
      hit = 0;
      e_pulse = 0;
      e_irq = 0;
      if (m_stepping) begin
         np = eff ? m_pos + 1 : m_pos - 1;
         if (np > 3) np = 3;
         if (np < 0) np = 0;
         e_irq = (np != m_pos) && (np == 0 || np == 3);
`ifdef ECE453_SEQ_BOUNCE_EN
         hit = m_step_auto && ((eff && np == 3) || (!eff && np == 0));
`endif
         m_pos = np;
         e_pulse = 1;
         m_stepping = 0;
         if (!enable) m_on = 0;
         else begin m_auto = auto_mode; m_left = m_per; end
      end else if (!m_on) begin
         if (enable) begin m_on = 1; m_auto = auto_mode; m_left = m_per; end
      end else if (!enable) begin
         m_on = 0;
      end else if (button_pulse) begin
         m_stepping = 1; m_step_auto = m_auto;
      end else if (auto_mode != m_auto) begin
         m_auto = auto_mode; m_left = m_per;
      end else if (m_auto) begin
         if (m_left <= 1) begin m_stepping = 1; m_step_auto = 1; end
         else m_left--;
      end
`ifdef ECE453_SEQ_BOUNCE_EN
      if (hit) begin m_bact = 1; m_bdir = !eff; end
      else if (!hold) m_bact = 0;
      m_prev_di = dir_in;
`endif
      e_dir = hit ? !eff : eff;
      if (period_load) m_per = (period_in < 2) ? 2 : int'(period_in);
   endtask

   // Drive one cycle of inputs, advance the model on the edge, compare #1 later.
   task automatic cyc(input bit en, input bit am, input bit di, input bit bp,
                      input bit pl, input int pin);
      enable = en; auto_mode = am; dir_in = di; button_pulse = bp;
      period_load = pl; period_in = PW'(pin);
      @(posedge clk);
      cyc_n++;
      model_edge();
      #1;
      chk("state", 32'(state), 32'(exp_state()));
      chk("position", 32'(position), 32'(m_pos));
      chk("step_pulse", 32'(step_pulse), 32'(e_pulse));
      chk("end_irq", 32'(end_irq), 32'(e_irq));
      chk("cur_dir", 32'(cur_dir), 32'(e_dir));
      if (step_pulse) begin pulse_t.push_back(cyc_n); pulse_pos.push_back(int'(position)); end
      if (end_irq) irq_pos.push_back(int'(position));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 0; auto_mode = 0; dir_in = 1; button_pulse = 0; period_load = 0; period_in = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_position", 32'(position), 32'd0);
      chk("rst_step_pulse", 32'(step_pulse), 32'd0);
      chk("rst_end_irq", 32'(end_irq), 32'd0);
      chk("rst_cur_dir", 32'(cur_dir), 32'd1);
   endtask

   task automatic clear_logs();
      pulse_t.delete(); pulse_pos.delete(); irq_pos.delete();
   endtask

   initial begin
      int bp_t, n_before, pos_before, guard;
      bit rn_en, rn_am, rn_di;

      // Manual: four spaced button presses, saturating at 3, one end_irq.
      do_reset();
      clear_logs();
      cyc(1, 0, 1, 0, 0, 0);
      bp_t = cyc_n;
      for (int k = 0; k < 4; k++) begin
         cyc(1, 0, 1, 1, 0, 0);
         repeat (4) cyc(1, 0, 1, 0, 0, 0);
      end
      chk("man_pulse_count", 32'(pulse_pos.size()), 32'd4);
      chk("man_pos0", 32'(pulse_pos[0]), 32'd1);
      chk("man_pos1", 32'(pulse_pos[1]), 32'd2);
      chk("man_pos2", 32'(pulse_pos[2]), 32'd3);
      chk("man_pos3", 32'(pulse_pos[3]), 32'd3);
      chk("man_irq_count", 32'(irq_pos.size()), 32'd1);
      chk("man_irq_pos", 32'(irq_pos[0]), 32'd3);
      chk("man_latency", 32'(pulse_t[0] - bp_t), 32'd2);

      // Auto with period 10: pulses 11 cycles apart, counting 1,2,3.
      do_reset();
      clear_logs();
      cyc(0, 1, 1, 0, 1, 10);
      guard = 0;
      while (pulse_t.size() < 3 && guard < 100) begin cyc(1, 1, 1, 0, 0, 0); guard++; end
      chk("auto_timeout", 32'(guard < 100), 32'd1);
      chk("auto_pos0", 32'(pulse_pos[0]), 32'd1);
      chk("auto_pos1", 32'(pulse_pos[1]), 32'd2);
      chk("auto_pos2", 32'(pulse_pos[2]), 32'd3);
      chk("auto_gap0", 32'(pulse_t[1] - pulse_t[0]), 32'd11);
      chk("auto_gap1", 32'(pulse_t[2] - pulse_t[1]), 32'd11);

      // Button coincident with timer expiry: one step, full period restarts.
      guard = 0;
      while (!(m_on && m_auto && !m_stepping && m_left == 1) && guard < 30) begin
         cyc(1, 1, 1, 0, 0, 0); guard++;
      end
      chk("coinc_timeout", 32'(guard < 30), 32'd1);
      clear_logs();
      bp_t = cyc_n;
      cyc(1, 1, 1, 1, 0, 0);
      repeat (14) cyc(1, 1, 1, 0, 0, 0);
      chk("coinc_pulses", 32'(pulse_t.size()), 32'd2);
      chk("coinc_first", 32'(pulse_t[0] - bp_t), 32'd2);
      chk("coinc_gap", 32'(pulse_t[1] - pulse_t[0]), 32'd11);

      // Period 0 clamps to 2 (3-cycle spacing); drop enable mid-count.
      clear_logs();
      cyc(1, 1, 1, 0, 1, 0);
      repeat (24) cyc(1, 1, 1, 0, 0, 0);
      chk("clamp_enough", 32'(pulse_t.size() >= 3), 32'd1);
      chk("clamp_gap0", 32'(pulse_t[pulse_t.size()-1] - pulse_t[pulse_t.size()-2]), 32'd3);
      chk("clamp_gap1", 32'(pulse_t[pulse_t.size()-2] - pulse_t[pulse_t.size()-3]), 32'd3);
      guard = 0;
      while (!(m_auto && !m_stepping && m_left == 2) && guard < 10) begin
         cyc(1, 1, 1, 0, 0, 0); guard++;
      end
      chk("drop_timeout", 32'(guard < 10), 32'd1);
      n_before = pulse_t.size();
      pos_before = int'(position);
      cyc(0, 1, 1, 0, 0, 0);
      chk("drop_idle", 32'(state), 32'd0);
      for (int k = 0; k < 10; k++) cyc(0, 1, 1, (k % 3) == 0, 0, 0);
      chk("drop_no_pulse", 32'(pulse_t.size()), 32'(n_before));
      chk("drop_pos_frozen", 32'(position), 32'(pos_before));

      // Auto period 4 toward 3: saturates by default, ping-pongs with bounce.
      do_reset();
      clear_logs();
      cyc(0, 1, 1, 0, 1, 4);
      guard = 0;
      while (pulse_t.size() < 7 && guard < 100) begin cyc(1, 1, 1, 0, 0, 0); guard++; end
      chk("end_timeout", 32'(guard < 100), 32'd1);
      chk("end_pos0", 32'(pulse_pos[0]), 32'd1);
      chk("end_pos1", 32'(pulse_pos[1]), 32'd2);
      chk("end_pos2", 32'(pulse_pos[2]), 32'd3);
`ifdef ECE453_SEQ_BOUNCE_EN
      chk("end_pos3", 32'(pulse_pos[3]), 32'd2);
      chk("end_pos4", 32'(pulse_pos[4]), 32'd1);
      chk("end_pos5", 32'(pulse_pos[5]), 32'd0);
      chk("end_pos6", 32'(pulse_pos[6]), 32'd1);
      chk("end_irq_count", 32'(irq_pos.size()), 32'd2);
      chk("end_irq_second", 32'(irq_pos[1]), 32'd0);
`else
      chk("end_pos3", 32'(pulse_pos[3]), 32'd3);
      chk("end_pos4", 32'(pulse_pos[4]), 32'd3);
      chk("end_irq_count", 32'(irq_pos.size()), 32'd1);
`endif
      chk("end_irq_first", 32'(irq_pos[0]), 32'd3);

      // Random traffic against the model.
      cyc(1, 1, 1, 0, 1, $urandom_range(0, 12));
      rn_en = 1; rn_am = 1; rn_di = 1;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 24) == 0) rn_en = !rn_en;
         if ($urandom_range(0, 30) == 0) rn_am = !rn_am;
         if ($urandom_range(0, 20) == 0) rn_di = !rn_di;
         cyc(rn_en, rn_am, rn_di, $urandom_range(0, 5) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 12));
      end

      // Asynchronous reset while in STEP with position 2.
      do_reset();
      cyc(1, 0, 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         cyc(1, 0, 1, 1, 0, 0);
         repeat (3) cyc(1, 0, 1, 0, 0, 0);
      end
      cyc(1, 0, 1, 1, 0, 0);
      chk("pre_rst_state", 32'(state), 32'd3);
      chk("pre_rst_pos", 32'(position), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_position", 32'(position), 32'd0);
      chk("arst_step_pulse", 32'(step_pulse), 32'd0);
      chk("arst_end_irq", 32'(end_irq), 32'd0);
      chk("arst_cur_dir", 32'(cur_dir), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
